// File: rtl/radix_8_inv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : radix_8_inv_pkg
// Description : Shared NTT constants and modular-multiply helper.
// Revision    : 1.0 - initial release
// ============================================================================
package radix_8_inv_pkg;

    // Transform geometry, common to the forward and inverse directions.
    localparam int c_NTT_POINTS     = 8;
    localparam int c_NTT_LOG_POINTS = 3;

    // Modulus, 8^-1 mod Q, and pipeline depth of the inverse transform.
    localparam int c_NTT_Q          = 12289;
    localparam int c_NTT_N_INV      = 10753;
    localparam int c_NTT_STAGES     = 5;

    // Operands are < 2^32, so the 64-bit product never overflows.
    function automatic logic [63:0] mod_mul(
        input logic [63:0] a,
        input logic [63:0] b,
        input logic [63:0] q
    );
        logic [63:0] prod;
        prod = a * b;
        return prod % q;
    endfunction

endpackage
`default_nettype wire

// File: rtl/radix_8_inv_gs_butterfly.sv
`default_nettype none
// ============================================================================
// Module      : gs_butterfly
// Description : Combinational Gentleman-Sande butterfly modulo Q.
// Revision    : 1.0 - initial release
// ============================================================================
module gs_butterfly
    import radix_8_inv_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int Q     = c_NTT_Q
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_w,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_b
);

    localparam logic [WIDTH:0] c_Q = (WIDTH+1)'(Q);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_sum_red;
    logic [WIDTH:0] w_diff;

    always_comb begin
        w_sum     = {1'b0, i_a} + {1'b0, i_b};
        w_sum_red = (w_sum >= c_Q) ? (w_sum - c_Q) : w_sum;
        w_diff    = (i_a >= i_b) ? ({1'b0, i_a} - {1'b0, i_b})
                                 : ({1'b0, i_a} + c_Q - {1'b0, i_b});
    end

    assign o_a = WIDTH'(w_sum_red);
    assign o_b = WIDTH'(mod_mul(64'(w_diff), 64'(i_w), 64'(Q)));

endmodule
`default_nettype wire

// File: rtl/radix_8_inv.sv
`default_nettype none
// ============================================================================
// Module      : radix_8_inv
// Description : Five-stage pipelined 8-point inverse NTT with psi post-weights.
// Revision    : 1.0 - initial release
// ============================================================================
module radix_8_inv
    import radix_8_inv_pkg::*;
#(
    parameter int WIDTH = 18,
    parameter int Q     = c_NTT_Q,
    parameter int N_INV = c_NTT_N_INV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] input_1,
    input  logic [WIDTH-1:0] input_2,
    input  logic [WIDTH-1:0] input_3,
    input  logic [WIDTH-1:0] input_4,
    input  logic [WIDTH-1:0] input_5,
    input  logic [WIDTH-1:0] input_6,
    input  logic [WIDTH-1:0] input_7,
    input  logic [WIDTH-1:0] input_8,
    input  logic [WIDTH-1:0] w_inv_0_8,
    input  logic [WIDTH-1:0] w_inv_1_8,
    input  logic [WIDTH-1:0] w_inv_2_8,
    input  logic [WIDTH-1:0] w_inv_3_8,
    input  logic [WIDTH-1:0] psi_inv_1,
    input  logic [WIDTH-1:0] psi_inv_2,
    input  logic [WIDTH-1:0] psi_inv_3,
    input  logic [WIDTH-1:0] psi_inv_4,
    input  logic [WIDTH-1:0] psi_inv_5,
    input  logic [WIDTH-1:0] psi_inv_6,
    input  logic [WIDTH-1:0] psi_inv_7,
    input  logic [WIDTH-1:0] psi_inv_8,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] output_1,
    output logic [WIDTH-1:0] output_2,
    output logic [WIDTH-1:0] output_3,
    output logic [WIDTH-1:0] output_4,
    output logic [WIDTH-1:0] output_5,
    output logic [WIDTH-1:0] output_6,
    output logic [WIDTH-1:0] output_7,
    output logic [WIDTH-1:0] output_8
);

    localparam int c_N = c_NTT_POINTS;

    logic                     w_en;
    logic [WIDTH-1:0]         w_in     [c_N];
    logic [WIDTH-1:0]         w_w      [4];
    logic [WIDTH-1:0]         w_psi    [c_N];
    logic [WIDTH-1:0]         w_s1_nxt [c_N];
    logic [WIDTH-1:0]         w_s2_nxt [c_N];
    logic [WIDTH-1:0]         w_s3_nxt [c_N];
    logic [WIDTH-1:0]         w_s4_nxt [c_N];
    logic [WIDTH-1:0]         w_s5_nxt [c_N];

    logic [c_NTT_STAGES-1:0]  r_v;
    logic [WIDTH-1:0]         r_s1     [c_N];
    logic [WIDTH-1:0]         r_s2     [c_N];
    logic [WIDTH-1:0]         r_s3     [c_N];
    logic [WIDTH-1:0]         r_s4     [c_N];
    logic [WIDTH-1:0]         r_s5     [c_N];
    logic [WIDTH-1:0]         r_s1_w0;
    logic [WIDTH-1:0]         r_s1_w2;
    logic [WIDTH-1:0]         r_s2_w0;
    logic [WIDTH-1:0]         r_s1_psi [c_N];
    logic [WIDTH-1:0]         r_s2_psi [c_N];
    logic [WIDTH-1:0]         r_s3_psi [c_N];

    // A single enable stalls the whole pipe whenever the output is blocked.
    assign w_en      = !r_v[c_NTT_STAGES-1] || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_v[c_NTT_STAGES-1];

    assign w_in  = '{input_1, input_2, input_3, input_4,
                     input_5, input_6, input_7, input_8};
    assign w_w   = '{w_inv_0_8, w_inv_1_8, w_inv_2_8, w_inv_3_8};
    assign w_psi = '{psi_inv_1, psi_inv_2, psi_inv_3, psi_inv_4,
                     psi_inv_5, psi_inv_6, psi_inv_7, psi_inv_8};

    generate
        for (genvar k = 0; k < 4; k++) begin : g_s1
            gs_butterfly #(.WIDTH(WIDTH), .Q(Q)) u_bf (
                .i_a (w_in[k]),
                .i_b (w_in[k+4]),
                .i_w (w_w[k]),
                .o_a (w_s1_nxt[k]),
                .o_b (w_s1_nxt[k+4])
            );
        end

        for (genvar g = 0; g < 2; g++) begin : g_s2_grp
            for (genvar j = 0; j < 2; j++) begin : g_s2_pair
                localparam int c_LO = 4*g + j;
                gs_butterfly #(.WIDTH(WIDTH), .Q(Q)) u_bf (
                    .i_a (r_s1[c_LO]),
                    .i_b (r_s1[c_LO+2]),
                    .i_w ((j == 0) ? r_s1_w0 : r_s1_w2),
                    .o_a (w_s2_nxt[c_LO]),
                    .o_b (w_s2_nxt[c_LO+2])
                );
            end
        end

        for (genvar k = 0; k < 4; k++) begin : g_s3
            gs_butterfly #(.WIDTH(WIDTH), .Q(Q)) u_bf (
                .i_a (r_s2[2*k]),
                .i_b (r_s2[2*k+1]),
                .i_w (r_s2_w0),
                .o_a (w_s3_nxt[2*k]),
                .o_b (w_s3_nxt[2*k+1])
            );
        end

        for (genvar k = 0; k < c_N; k++) begin : g_scale
            assign w_s4_nxt[k] = WIDTH'(mod_mul(64'(r_s3[k]), 64'(r_s3_psi[k]), 64'(Q)));
            assign w_s5_nxt[k] = WIDTH'(mod_mul(64'(r_s4[k]), 64'(N_INV), 64'(Q)));
        end
    endgenerate

    // Stage data only loads behind a valid vector, so bubbles never overwrite it.
    always_ff @(posedge clk) begin
        if (w_en) begin
            if (in_valid) begin
                r_s1     <= w_s1_nxt;
                r_s1_w0  <= w_inv_0_8;
                r_s1_w2  <= w_inv_2_8;
                r_s1_psi <= w_psi;
            end
            if (r_v[0]) begin
                r_s2     <= w_s2_nxt;
                r_s2_w0  <= r_s1_w0;
                r_s2_psi <= r_s1_psi;
            end
            if (r_v[1]) begin
                r_s3     <= w_s3_nxt;
                r_s3_psi <= r_s2_psi;
            end
            if (r_v[2]) begin
                r_s4     <= w_s4_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_v  <= '0;
            r_s5 <= '{default: '0};
        end else if (w_en) begin
            r_v <= {r_v[c_NTT_STAGES-2:0], in_valid};
            if (r_v[3]) begin
                r_s5 <= w_s5_nxt;
            end
        end
    end

    assign output_1 = r_s5[0];
    assign output_2 = r_s5[1];
    assign output_3 = r_s5[2];
    assign output_4 = r_s5[3];
    assign output_5 = r_s5[4];
    assign output_6 = r_s5[5];
    assign output_7 = r_s5[6];
    assign output_8 = r_s5[7];

endmodule
`default_nettype wire

// File: tb/tb_radix_8_inv.sv
`default_nettype none
// ============================================================================
// Module      : tb_radix_8_inv
// Description : Directed and streaming checks of radix_8_inv against a golden model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_radix_8_inv;

    localparam int c_W     = 18;
    localparam int c_Q     = 12289;
    localparam int c_N_INV = 10753;

    typedef logic [7:0][c_W-1:0] lanes_t;
    typedef struct packed {
        logic [7:0][c_W-1:0] d;
        logic [3:0][c_W-1:0] w;
        logic [7:0][c_W-1:0] p;
    } vec_t;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   in_valid;
    logic   in_ready;
    logic   out_valid;
    logic   out_ready;
    vec_t   drv;
    lanes_t w_out;
    logic [c_W-1:0] o1, o2, o3, o4, o5, o6, o7, o8;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign w_out = {o8, o7, o6, o5, o4, o3, o2, o1};

    radix_8_inv #(.WIDTH(c_W), .Q(c_Q), .N_INV(c_N_INV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .input_1   (drv.d[0]), .input_2 (drv.d[1]), .input_3 (drv.d[2]), .input_4 (drv.d[3]),
        .input_5   (drv.d[4]), .input_6 (drv.d[5]), .input_7 (drv.d[6]), .input_8 (drv.d[7]),
        .w_inv_0_8 (drv.w[0]), .w_inv_1_8 (drv.w[1]), .w_inv_2_8 (drv.w[2]), .w_inv_3_8 (drv.w[3]),
        .psi_inv_1 (drv.p[0]), .psi_inv_2 (drv.p[1]), .psi_inv_3 (drv.p[2]), .psi_inv_4 (drv.p[3]),
        .psi_inv_5 (drv.p[4]), .psi_inv_6 (drv.p[5]), .psi_inv_7 (drv.p[6]), .psi_inv_8 (drv.p[7]),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .output_1  (o1), .output_2 (o2), .output_3 (o3), .output_4 (o4),
        .output_5  (o5), .output_6 (o6), .output_7 (o7), .output_8 (o8)
    );

    // Reference inverse transform written directly from the butterfly schedule.
    function automatic lanes_t golden(input vec_t v);
        longint x [8];
        longint t;
        lanes_t r;
        for (int i = 0; i < 8; i++) x[i] = longint'(v.d[i]);
        for (int k = 0; k < 4; k++) begin
            t = x[k];
            x[k]   = (t + x[k+4]) % c_Q;
            x[k+4] = (((t - x[k+4] + c_Q) % c_Q) * longint'(v.w[k])) % c_Q;
        end
        for (int g = 0; g < 8; g += 4) begin
            for (int j = 0; j < 2; j++) begin
                t = x[g+j];
                x[g+j]   = (t + x[g+j+2]) % c_Q;
                x[g+j+2] = (((t - x[g+j+2] + c_Q) % c_Q) * longint'(v.w[2*j])) % c_Q;
            end
        end
        for (int k = 0; k < 4; k++) begin
            t = x[2*k];
            x[2*k]   = (t + x[2*k+1]) % c_Q;
            x[2*k+1] = (((t - x[2*k+1] + c_Q) % c_Q) * longint'(v.w[0])) % c_Q;
        end
        for (int i = 0; i < 8; i++) begin
            x[i] = ((x[i] * longint'(v.p[i])) % c_Q) * c_N_INV % c_Q;
            r[i] = c_W'(x[i]);
        end
        return r;
    endfunction

    function automatic vec_t unit_weights(input lanes_t d);
        vec_t v;
        v.d = d;
        for (int i = 0; i < 4; i++) v.w[i] = c_W'(1);
        for (int i = 0; i < 8; i++) v.p[i] = c_W'(1);
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < 8; i++) v.d[i] = c_W'($urandom_range(0, c_Q-1));
        for (int i = 0; i < 4; i++) v.w[i] = c_W'($urandom_range(0, c_Q-1));
        for (int i = 0; i < 8; i++) v.p[i] = c_W'($urandom_range(0, c_Q-1));
        return v;
    endfunction

    // Drive one vector with out_ready high and report cycles until out_valid.
    task automatic send_one(input vec_t v, output int lat, output lanes_t res);
        lat = -1;
        res = '0;
        @(negedge clk);
        drv       = v;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            #1;
            if (out_valid) begin
                lat = k;
                res = w_out;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drv       = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        checks++;
        if (w_out !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", w_out);
        end
    endtask

    task automatic test_directed(input string name, input lanes_t d, input lanes_t exp);
        int     lat;
        lanes_t res;
        send_one(unit_weights(d), lat, res);
        checks++;
        if (lat !== 5) begin
            failures++;
            $display("FAIL %s_latency: got %0d expected 5", name, lat);
        end
        checks++;
        if (res !== exp) begin
            failures++;
            $display("FAIL %s_value: got %h expected %h", name, res, exp);
        end
    endtask

    task automatic test_all_ones();
        lanes_t d, e;
        for (int i = 0; i < 8; i++) d[i] = c_W'(1);
        e    = '0;
        e[0] = c_W'(1);
        test_directed("all_ones", d, e);
    endtask

    task automatic test_impulse();
        lanes_t d, e;
        d    = '0;
        d[0] = c_W'(1);
        for (int i = 0; i < 8; i++) e[i] = c_W'(10753);
        test_directed("impulse", d, e);
    endtask

    task automatic test_wrap();
        lanes_t d, e;
        d    = '0;
        d[4] = c_W'(12288);
        // -1 * 8^-1 = -10753 = 1536 in the low half; 1 * 8^-1 in the high half.
        for (int i = 0; i < 4; i++) e[i] = c_W'(1536);
        for (int i = 4; i < 8; i++) e[i] = c_W'(10753);
        test_directed("wrap", d, e);
        checks++;
        if (golden(unit_weights(d)) !== e) begin
            failures++;
            $display("FAIL wrap_model: got %h expected %h", golden(unit_weights(d)), e);
        end
    endtask

    task automatic test_stall_hold();
        vec_t   va, vb;
        lanes_t res;
        int     cnt;
        logic   seen;
        va = rand_vec();
        vb = rand_vec();
        @(negedge clk);
        drv       = va;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        seen     = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL stall_fill_timeout: got out_valid=0 expected 1");
        end
        drv      = vb;
        in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_in_ready: got %b expected 0", in_ready);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || w_out !== golden(va)) begin
            failures++;
            $display("FAIL stall_hold: got v=%b %h expected v=1 %h", out_valid, w_out, golden(va));
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release_ready: got %b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        res = '0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (out_valid) begin
                cnt++;
                res = w_out;
            end
            @(negedge clk);
        end
        checks++;
        if (cnt !== 1 || res !== golden(vb)) begin
            failures++;
            $display("FAIL stall_single_accept: got count=%0d %h expected count=1 %h", cnt, res, golden(vb));
        end
    endtask

    task automatic test_back_to_back();
        vec_t   vecs [20];
        lanes_t exp_q[$];
        lanes_t e;
        int     sent = 0;
        int     got  = 0;
        int     extra = 0;
        for (int i = 0; i < 20; i++) vecs[i] = rand_vec();
        for (int c = 0; c < 400 && got < 20; c++) begin
            @(negedge clk);
            if (sent < 20) begin
                drv      = vecs[sent];
                in_valid = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                failures++;
                $display("FAIL b2b_in_ready: got %b expected %b", in_ready, !(out_valid && !out_ready));
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra_output: got %h expected none", w_out);
                end else begin
                    e = exp_q.pop_front();
                    if (w_out !== e) begin
                        failures++;
                        $display("FAIL b2b_value[%0d]: got %h expected %h", got, w_out, e);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(golden(drv));
                sent++;
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            if (out_valid) extra++;
            @(negedge clk);
        end
        checks++;
        if (got !== 20 || sent !== 20 || exp_q.size() !== 0 || extra !== 0) begin
            failures++;
            $display("FAIL b2b_count: got sent=%0d recv=%0d pending=%0d extra=%0d expected 20/20/0/0",
                     sent, got, exp_q.size(), extra);
        end
    endtask

    task automatic test_reset_mid();
        logic   seen = 1'b0;
        int     lat;
        lanes_t res;
        lanes_t d, e;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drv      = rand_vec();
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_valid: got out_valid=1 expected 0");
        end
        checks++;
        if (w_out !== '0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got %h expected 0", w_out);
        end
        d    = '0;
        d[0] = c_W'(1);
        for (int i = 0; i < 8; i++) e[i] = c_W'(10753);
        send_one(unit_weights(d), lat, res);
        checks++;
        if (lat !== 5 || res !== e) begin
            failures++;
            $display("FAIL reset_mid_resume: got lat=%0d %h expected lat=5 %h", lat, res, e);
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_impulse();
        test_wrap();
        test_stall_hold();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/radix_8_inv.md
RADIX_8_INV -- requirements
Module: radix_8_inv

Interface
REQ-001 Parameter WIDTH, default 18; data and weight word width.
REQ-002 Parameter Q, default 12289; NTT modulus, Q < 2^WIDTH.
REQ-003 Parameter N_INV, default 10753; 8^-1 mod Q.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  input vector and weights are valid this cycle.
REQ-007 in_ready  output  1  block accepts a vector this cycle.
REQ-008 input_1..input_8  input  WIDTH each  NTT-domain coefficients, each < Q.
REQ-009 w_inv_0_8..w_inv_3_8  input  WIDTH each  inverse butterfly twiddles, each < Q.
REQ-010 psi_inv_1..psi_inv_8  input  WIDTH each  inverse psi post-weights, each < Q.
REQ-011 out_valid  output  1  output vector valid.
REQ-012 out_ready  input  1  downstream accepts the output vector.
REQ-013 output_1..output_8  output  WIDTH each  coefficient-domain results, each < Q.

Function
REQ-014 Transfers: an input is accepted on cycles where in_valid && in_ready; an output is consumed on cycles where out_valid && out_ready.
REQ-015 Five-stage pipeline S1..S5, each stage with its own valid bit; data and all weights are captured with the vector and travel with it.
REQ-016 Global advance enable en = !out_valid || out_ready; in_ready = en; when en=0 every stage holds data and valid.
REQ-017 Latency: a vector accepted at cycle t appears with out_valid=1 at cycle t+5 when there is no stall; throughput is one vector per cycle.
REQ-018 Gentleman-Sande butterfly (a,b,w): a' = (a+b) mod Q; b' = ((a-b) mod Q)*w mod Q; subtraction adds Q when a<b.
REQ-019 S1: pairs (1,5),(2,6),(3,7),(4,8) use w_inv_0,1,2,3 respectively.
REQ-020 S2: pairs (1,3),(2,4),(5,7),(6,8) use w_inv_0,2,0,2 respectively.
REQ-021 S3: pairs (1,2),(3,4),(5,6),(7,8) all use w_inv_0.
REQ-022 S4: lane k = lane k * psi_inv_k mod Q.
REQ-023 S5: lane k = lane k * N_INV mod Q; output_k is the S5 lane k register.
REQ-024 Products are formed at full 2*WIDTH width before reduction; every stage register holds a value < Q.
REQ-025 An invalid stage holds the data bits of its last update; a bubble does not corrupt older valid vectors.
REQ-026 Simultaneous accept and consume under full occupancy proceeds with no loss or duplication.
REQ-027 Inputs >= Q are outside the contract; output values for such inputs are unspecified, but handshake behaviour is unaffected.

Reset
REQ-028 While rst_n=0 at a rising edge, all stage valid bits and out_valid clear to 0 and all output_k clear to 0.
REQ-029 in_ready is 1 in the first cycle after reset, since out_valid=0.
REQ-030 Reset mid-operation discards all in-flight vectors; no out_valid is asserted for them afterwards.

Structure
REQ-031 Q, N_INV and the stage count belong in the shared NTT package, alongside the forward-transform constants.
REQ-032 One sub-module, gs_butterfly (parameters WIDTH, Q; combinational add, subtract and modular multiply), is instantiated 12 times.
REQ-033 The modular multiply is a function in the shared package, reused by S4, S5 and gs_butterfly.

Verification
REQ-034 All inputs=1, all w_inv=1, all psi_inv=1, out_ready=1 -> after 5 cycles output_1=1 and output_2..8=0.
REQ-035 input_1=1, others 0, all weights=1 -> output_1..8 all equal 10753.
REQ-036 Wrap-around: input_1=0, input_5=12288, weights=1 -> S1 lane5 difference = 1, checked against a golden model.
REQ-037 Back-to-back stream of 20 random vectors with random out_ready stalls -> output order and values match the golden model, with no drops or duplicates; in_ready=0 exactly when out_valid=1 and out_ready=0.
REQ-038 Assert rst_n=0 for one cycle with 3 vectors in flight -> out_valid stays 0 until a new vector is accepted and output_k=0 after reset.
REQ-039 Input held while in_ready=0 -> that vector is accepted exactly once, on the cycle in_ready returns to 1.
